// File: rtl/mont_mul_pipe.sv
// rtl/mont_mul_pipe.sv - pipelined multi-lane Montgomery multiplier with valid/ready flow control
module mont_mul_pipe #(
    parameter int WIDTH = 16,
    parameter int Q     = 3329,
    parameter int QINV  = -3327,
    parameter int LANES = 1,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [LANES*WIDTH-1:0]  in_a,
    input  logic [LANES*WIDTH-1:0]  in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*WIDTH-1:0]  out_r,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int W2 = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] QINV_W = WIDTH'(QINV);
    localparam logic signed [WIDTH-1:0] Q_W    = WIDTH'(Q);
    localparam logic signed [W2-1:0]    Q_2W   = W2'(Q);

    logic               r_v1, r_v2, r_v3;
    logic               r_mode1, r_mode2;
    logic [TAG_W-1:0]   r_tag1, r_tag2, r_tag3;
    logic               w_adv;

    // The whole pipe moves as one; only a held output result can freeze it.
    assign w_adv     = ~(r_v3 & ~out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign out_tag   = r_tag3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_mode1 <= 1'b0;
            r_mode2 <= 1'b0;
            r_tag1  <= '0;
            r_tag2  <= '0;
            r_tag3  <= '0;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_mode1 <= in_mode;
            r_mode2 <= r_mode1;
            r_tag1  <= in_tag;
            r_tag2  <= r_tag1;
            r_tag3  <= r_tag2;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic signed [WIDTH-1:0] w_a, w_b, w_t, w_r, w_rc;
            logic signed [W2-1:0]    w_p, w_tq;
            logic signed [W2-1:0]    r_p1, r_p2;
            logic signed [WIDTH-1:0] r_t2, r_r3;

            assign w_a  = in_a[g*WIDTH +: WIDTH];
            assign w_b  = in_b[g*WIDTH +: WIDTH];
            assign w_p  = W2'(w_a) * W2'(w_b);
            // Only the low WIDTH bits of p*QINV matter, so the product is kept at WIDTH bits.
            assign w_t  = r_p1[WIDTH-1:0] * QINV_W;
            assign w_tq = W2'(r_t2) * Q_2W;
            // p - t*Q has all-zero low bits, so the arithmetic shift is an exact division.
            assign w_r  = WIDTH'((r_p2 - w_tq) >>> WIDTH);
            assign w_rc = (r_mode2 && w_r[WIDTH-1]) ? w_r + Q_W : w_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_p1 <= '0;
                    r_p2 <= '0;
                    r_t2 <= '0;
                    r_r3 <= '0;
                end else if (w_adv) begin
                    r_p1 <= w_p;
                    r_p2 <= r_p1;
                    r_t2 <= w_t;
                    r_r3 <= w_rc;
                end
            end

            assign out_r[g*WIDTH +: WIDTH] = r_r3;
        end
    endgenerate

endmodule

// File: tb/tb_mont_mul_pipe.sv
// tb/tb_mont_mul_pipe.sv - scoreboard bench for mont_mul_pipe, four 16-bit lanes
module tb_mont_mul_pipe;

    localparam int QM = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [3:0]  in_tag, out_tag;
    logic [63:0] in_a, in_b, out_r;

    typedef struct {
        logic [63:0] r;
        logic [3:0]  tag;
        logic        mode;
        logic        rng;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [63:0] drv_exp;
    logic        drv_rng;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          bp_base = 0;
    int          rdy_pol = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_r;
    logic [3:0]  prev_tag;
    logic signed [15:0] rl;
    logic        rok;

    mont_mul_pipe #(.WIDTH(16), .Q(3329), .QINV(-3327), .LANES(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic signed [15:0] mont0(input logic signed [15:0] a, input logic signed [15:0] b);
        longint p, pq, u;
        logic [15:0] lo;
        logic signed [15:0] t;
        p  = longint'(a) * longint'(b);
        lo = p[15:0];
        pq = longint'($signed(lo)) * -3327;
        t  = pq[15:0];
        u  = p - longint'(t) * QM;
        return u[31:16];
    endfunction

    // Canonical a*b*2^-16 mod Q, with 2^-16 == 169 (mod 3329).
    function automatic logic signed [15:0] canon(input logic signed [15:0] a, input logic signed [15:0] b);
        longint x;
        x = (longint'(a) * longint'(b)) % QM;
        x = (x * 169) % QM;
        if (x < 0) x = x + QM;
        return 16'(x);
    endfunction

    function automatic logic [63:0] exp4(input logic [63:0] a, input logic [63:0] b, input logic m);
        logic [63:0] r;
        for (int l = 0; l < 4; l++)
            r[l*16 +: 16] = m ? canon(a[l*16 +: 16], b[l*16 +: 16]) : mont0(a[l*16 +: 16], b[l*16 +: 16]);
        return r;
    endfunction

    function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    function automatic logic [63:0] rnd4();
        logic [63:0] v;
        int x;
        for (int l = 0; l < 4; l++) begin
            x = int'($urandom_range(0, 2*QM - 2)) - (QM - 1);
            v[l*16 +: 16] = 16'(x);
        end
        return v;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_pol)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = !((cyc - bp_base) >= 4 && (cyc - bp_base) <= 7);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor and scoreboard; inputs/ready only change just after posedge.
    always @(negedge clk) begin
        if (prev_stall) begin
            n_vec++;
            assert (out_valid === 1'b1 && out_r === prev_r && out_tag === prev_tag) else begin
                n_err++;
                $error("FAIL hold_stable valid=%b out_r=%h tag=%0d required valid=1 out_r=%h tag=%0d",
                       out_valid, out_r, out_tag, prev_r, prev_tag);
            end
        end
        n_vec++;
        assert (in_ready === !(out_valid && !out_ready)) else begin
            n_err++;
            $error("FAIL in_ready got=%b required=%b", in_ready, !(out_valid && !out_ready));
        end
        if (out_valid === 1'b1 && out_ready) begin
            n_vec++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_output out_r=%h tag=%0d required no result", out_r, out_tag);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                assert (out_r === e.r && out_tag === e.tag) else begin
                    n_err++;
                    $error("FAIL result out_r=%h tag=%0d required out_r=%h tag=%0d", out_r, out_tag, e.r, e.tag);
                end
                if (e.rng) begin
                    rok = 1'b1;
                    for (int l = 0; l < 4; l++) begin
                        rl = out_r[l*16 +: 16];
                        if (e.mode ? (rl < 0 || rl >= QM) : (rl <= -QM || rl >= QM)) rok = 1'b0;
                    end
                    n_vec++;
                    assert (rok) else begin
                        n_err++;
                        $error("FAIL range mode=%b out_r=%h required every lane inside the mode range", e.mode, out_r);
                    end
                end
            end
        end
        if (in_valid && in_ready) q.push_back('{r: drv_exp, tag: in_tag, mode: in_mode, rng: drv_rng});
        prev_stall = out_valid && !out_ready;
        prev_r     = out_r;
        prev_tag   = out_tag;
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic m,
                        input logic [3:0] tag, input logic [63:0] ex, input logic rng);
        bit ok;
        int budget;
        in_a = a; in_b = b; in_mode = m; in_tag = tag;
        drv_exp = ex; drv_rng = rng; in_valid = 1'b1;
        ok = 1'b0;
        budget = 0;
        while (!ok && budget < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            budget++;
        end
        n_vec++;
        assert (ok) else begin
            n_err++;
            $error("FAIL send_timeout in_ready=%b required 1 within 200 cycles", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (q.size() != 0 && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        n_vec++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL drain pending=%0d required 0", q.size());
        end
    endtask

    initial begin
        logic [63:0] a, b;
        logic        m;
        int          cnt;

        rst = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_tag = '0; in_a = '0; in_b = '0;
        drv_exp = '0; drv_rng = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        assert (out_valid === 1'b0 && out_r === 64'h0 && out_tag === 4'h0 && in_ready === 1'b1) else begin
            n_err++;
            $error("FAIL reset_state valid=%b r=%h tag=%0d in_ready=%b required 0/0/0/1", out_valid, out_r, out_tag, in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Single op with latency and one-cycle valid pulse.
        send(pk(1, -1, 2285, 0), pk(1, 1, 1234, 3000), 1'b0, 4'd5, pk(169, -169, 1234, 0), 1'b0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) cnt++;
            if (i == 2) begin
                n_vec++;
                assert (out_valid === 1'b1) else begin
                    n_err++;
                    $error("FAIL latency out_valid=%b required 1 on third edge", out_valid);
                end
            end
        end
        n_vec++;
        assert (cnt == 1) else begin
            n_err++;
            $error("FAIL valid_pulse cycles=%0d required 1", cnt);
        end
        @(posedge clk); #1;

        send(pk(1, -1, 2285, 0), pk(1, 1, 1234, 3000), 1'b1, 4'd6, pk(169, 3160, 1234, 0), 1'b0);
        send(pk(-32768, 0, -32768, -32768), pk(1, -32768, 0, -32768), 1'b0, 4'd7, pk(1664, 0, 0, 16384), 1'b0);
        send(pk(-32768, 0, 1, -1), pk(1, 3000, 1, 1), 1'b1, 4'd8, pk(1664, 0, 169, 3160), 1'b0);
        drain();

        // Eight back-to-back ops with out_ready dropped for cycles 4..7.
        bp_base = cyc;
        rdy_pol = 2;
        for (int t = 0; t < 8; t++) begin
            a = rnd4(); b = rnd4(); m = t[0];
            send(a, b, m, 4'(t), exp4(a, b, m), 1'b1);
        end
        drain();
        rdy_pol = 0;

        // Reset while three ops are in flight.
        for (int t = 0; t < 3; t++) begin
            a = rnd4(); b = rnd4();
            send(a, b, 1'b0, 4'(t + 9), exp4(a, b, 1'b0), 1'b1);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        assert (out_valid === 1'b0 && out_r === 64'h0 && out_tag === 4'h0 && in_ready === 1'b1) else begin
            n_err++;
            $error("FAIL midflight_reset valid=%b r=%h tag=%0d in_ready=%b required 0/0/0/1", out_valid, out_r, out_tag, in_ready);
        end
        q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) cnt++;
        end
        n_vec++;
        assert (cnt == 0) else begin
            n_err++;
            $error("FAIL stale_result valid_cycles=%0d required 0", cnt);
        end
        @(posedge clk); #1;

        // Random operands, bubbles and backpressure.
        rdy_pol = 1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            a = rnd4(); b = rnd4(); m = 1'($urandom_range(0, 1));
            send(a, b, m, 4'($urandom_range(0, 15)), exp4(a, b, m), 1'b1);
        end
        rdy_pol = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
